// File: rtl/arm_data_mem_arbiter.sv
// arm_data_mem_arbiter
//   Shares one single-port data memory between requester A (CPU load/store)
//   and requester B (program loader / debug). Grants are combinational with
//   round-robin tie breaking. A granted access carrying Lock=1 lets its owner
//   keep exclusive eligibility for up to MaxLock consecutive accesses. The
//   memory read is combinational; a granted read is captured and returned
//   to its port one cycle later.
//
//   Optional feature macro: ARB_B_WRITE_PROTECT_EN
//     When defined, B writes to word addresses below ProtectBase are granted
//     but not written, and o_B_Err pulses in the following cycle. When it is
//     undefined, o_B_Err is tied to 0.
//
// Ports
//   i_CLK, i_RESET_N              clock, synchronous active-low reset
//   i_X_Req/Lock/WE/Addr/WData    request from port X (X = A, B)
//   o_X_Gnt                       port X access performed this cycle
//   o_X_RValid, o_X_RData         registered read return for port X
//   o_B_Err                       suppressed B write (one-cycle pulse)
//   o_Mem_WE/Addr/WData           memory request (muxed from the granted port)
//   i_Mem_RData                   combinational memory read data
module arm_data_mem_arbiter #(
  parameter int BusWidth    = 32,
  parameter int MaxLock     = 4,
  parameter int ProtectBase = 16
) (
  input  logic                i_CLK,
  input  logic                i_RESET_N,
  input  logic                i_A_Req,
  input  logic                i_A_Lock,
  input  logic                i_A_WE,
  input  logic [BusWidth-1:0] i_A_Addr,
  input  logic [BusWidth-1:0] i_A_WData,
  output logic                o_A_Gnt,
  output logic                o_A_RValid,
  output logic [BusWidth-1:0] o_A_RData,
  input  logic                i_B_Req,
  input  logic                i_B_Lock,
  input  logic                i_B_WE,
  input  logic [BusWidth-1:0] i_B_Addr,
  input  logic [BusWidth-1:0] i_B_WData,
  output logic                o_B_Gnt,
  output logic                o_B_RValid,
  output logic [BusWidth-1:0] o_B_RData,
  output logic                o_B_Err,
  output logic                o_Mem_WE,
  output logic [BusWidth-1:0] o_Mem_Addr,
  output logic [BusWidth-1:0] o_Mem_WData,
  input  logic [BusWidth-1:0] i_Mem_RData
);

  localparam int CW = $clog2(MaxLock + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MaxLock);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lastb_q;       // 1: B was granted last, so A wins a tie
  logic          gnt_a, gnt_b;
  logic          own_hit;       // grant continues the current ownership
  logic          g_lock;
  logic          b_prot;        // granted B write that must be suppressed

  logic                a_rvalid_q, b_rvalid_q;
  logic [BusWidth-1:0] a_rdata_q, b_rdata_q;

  // Owner keeps exclusive eligibility only while it keeps requesting;
  // otherwise fall through to plain round-robin in the same cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (i_RESET_N) begin
      if (state_q == OWN_A && i_A_Req)      gnt_a = 1'b1;
      else if (state_q == OWN_B && i_B_Req) gnt_b = 1'b1;
      else if (i_A_Req && i_B_Req) begin
        if (lastb_q) gnt_a = 1'b1;
        else         gnt_b = 1'b1;
      end
      else if (i_A_Req) gnt_a = 1'b1;
      else if (i_B_Req) gnt_b = 1'b1;
    end
  end

  assign own_hit = (state_q == OWN_A && gnt_a) || (state_q == OWN_B && gnt_b);
  assign g_lock  = gnt_a ? i_A_Lock : i_B_Lock;
  assign cnt_d   = cnt_q + CW'(1);

`ifdef ARB_B_WRITE_PROTECT_EN
  logic b_err_q;
  assign b_prot = gnt_b & i_B_WE & (i_B_Addr < BusWidth'(ProtectBase));

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) b_err_q <= 1'b0;
    else            b_err_q <= b_prot;
  end

  assign o_B_Err = b_err_q;
`else
  assign b_prot  = 1'b0;
  assign o_B_Err = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lastb_q    <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= gnt_a & ~i_A_WE;
      b_rvalid_q <= gnt_b & ~i_B_WE;
      if (gnt_a & ~i_A_WE) a_rdata_q <= i_Mem_RData;
      if (gnt_b & ~i_B_WE) b_rdata_q <= i_Mem_RData;

      if (gnt_a | gnt_b) begin
        lastb_q <= gnt_b;
        if (own_hit) begin
          if (!g_lock || cnt_d >= MAX_CNT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end else if (g_lock && MaxLock > 1) begin
          state_q <= gnt_a ? OWN_A : OWN_B;
          cnt_q   <= CW'(1);
        end else begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end else begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end
    end
  end

  assign o_A_Gnt     = gnt_a;
  assign o_B_Gnt     = gnt_b;
  assign o_A_RValid  = a_rvalid_q;
  assign o_B_RValid  = b_rvalid_q;
  assign o_A_RData   = a_rdata_q;
  assign o_B_RData   = b_rdata_q;

  assign o_Mem_WE    = gnt_a ? i_A_WE : (gnt_b & i_B_WE & ~b_prot);
  assign o_Mem_Addr  = gnt_a ? i_A_Addr  : (gnt_b ? i_B_Addr  : '0);
  assign o_Mem_WData = gnt_a ? i_A_WData : (gnt_b ? i_B_WData : '0);

endmodule

// File: tb/tb_arm_data_mem_arbiter.sv
// Directed + randomized bench for arm_data_mem_arbiter. A small memory
// sits behind the arbiter; a reference model (owner/count bookkeeping plus
// an array mirror of the memory) predicts every cycle's grants, memory
// request and read return.
module tb_arm_data_mem_arbiter;
  localparam int BW = 32;
  localparam int ML = 4;
  localparam int PB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, a_lock, a_we, b_req, b_lock, b_we;
  logic [BW-1:0] a_addr, a_wdata, b_addr, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, b_err;
  logic [BW-1:0] a_rdata, b_rdata;
  logic          mem_we;
  logic [BW-1:0] mem_addr, mem_wdata, mem_rdata;

  arm_data_mem_arbiter #(.BusWidth(BW), .MaxLock(ML), .ProtectBase(PB)) dut (
    .i_CLK(clk), .i_RESET_N(rst_n),
    .i_A_Req(a_req), .i_A_Lock(a_lock), .i_A_WE(a_we), .i_A_Addr(a_addr),
    .i_A_WData(a_wdata), .o_A_Gnt(a_gnt), .o_A_RValid(a_rvalid), .o_A_RData(a_rdata),
    .i_B_Req(b_req), .i_B_Lock(b_lock), .i_B_WE(b_we), .i_B_Addr(b_addr),
    .i_B_WData(b_wdata), .o_B_Gnt(b_gnt), .o_B_RValid(b_rvalid), .o_B_RData(b_rdata),
    .o_B_Err(b_err), .o_Mem_WE(mem_we), .o_Mem_Addr(mem_addr),
    .o_Mem_WData(mem_wdata), .i_Mem_RData(mem_rdata)
  );

  // environment memory: combinational read, synchronous write, cleared by reset
  logic [BW-1:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  // reference model state
  int            own;       // 0 none, 1 A, 2 B
  int            ocnt;
  bit            lastb;
  logic [BW-1:0] rmem [0:63];
  bit            e_rva, e_rvb, e_err;
  logic [BW-1:0] e_rda, e_rdb;
  int            last_win;
  logic          obs_we;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit ra, la, wa, input logic [BW-1:0] aa, da,
                     input bit rb, lb, wb, input logic [BW-1:0] ab, db);
    int  win;
    bit  prot, ewe, lk;
    logic [BW-1:0] eaddr, ewd;
    rst_n = rst;
    a_req = ra; a_lock = la; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_lock = lb; b_we = wb; b_addr = ab; b_wdata = db;
    #3;
    win = 0;
    if (rst) begin
      if (own == 1 && ra)      win = 1;
      else if (own == 2 && rb) win = 2;
      else if (ra && rb)       win = lastb ? 1 : 2;
      else if (ra)             win = 1;
      else if (rb)             win = 2;
    end
    prot = 1'b0;
`ifdef ARB_B_WRITE_PROTECT_EN
    prot = (win == 2) && wb && (ab < PB);
`endif
    ewe   = (win == 1) ? wa : ((win == 2) ? (wb && !prot) : 1'b0);
    eaddr = (win == 1) ? aa : ((win == 2) ? ab : '0);
    ewd   = (win == 1) ? da : ((win == 2) ? db : '0);
    chk("a_gnt", 32'(a_gnt), 32'(win == 1));
    chk("b_gnt", 32'(b_gnt), 32'(win == 2));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", mem_addr, eaddr);
    chk("mem_wdata", mem_wdata, ewd);
    obs_we   = mem_we;
    last_win = win;
    @(posedge clk);
    #1;
    if (!rst) begin
      own = 0; ocnt = 0; lastb = 1'b1;
      e_rva = 0; e_rvb = 0; e_err = 0; e_rda = '0; e_rdb = '0;
      for (int i = 0; i < 64; i++) rmem[i] = '0;
    end else begin
      e_rva = (win == 1) && !wa;
      e_rvb = (win == 2) && !wb;
      if (e_rva) e_rda = rmem[aa[5:0]];
      if (e_rvb) e_rdb = rmem[ab[5:0]];
      e_err = prot;
      if (ewe) rmem[eaddr[5:0]] = ewd;
      if (win != 0) begin
        lk = (win == 1) ? la : lb;
        if (own == win) begin
          ocnt++;
          if (!lk || ocnt >= ML) begin own = 0; ocnt = 0; end
        end else if (lk && ML > 1) begin
          own = win; ocnt = 1;
        end else begin
          own = 0; ocnt = 0;
        end
        lastb = (win == 2);
      end else begin
        own = 0; ocnt = 0;
      end
    end
    chk("a_rvalid", 32'(a_rvalid), 32'(e_rva));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_rvb));
    chk("a_rdata", a_rdata, e_rda);
    chk("b_rdata", b_rdata, e_rdb);
    chk("b_err", 32'(b_err), 32'(e_err));
  endtask

  bit            pa, pla, pwa, pb, plb, pwb;
  logic [BW-1:0] paa, pda, pab, pdb;
  int            prev;

  initial begin
    own = 0; ocnt = 0; lastb = 1'b1; last_win = 0; obs_we = 1'b0;
    e_rva = 0; e_rvb = 0; e_err = 0; e_rda = '0; e_rdb = '0;
    for (int i = 0; i < 64; i++) rmem[i] = '0;

    // reset held two cycles with both requesting
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("rst_rvalid_a", 32'(a_rvalid), 0);
    // first tie goes to A, next to B
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("tie1_A", last_win, 1);
    cyc(1, 1, 0, 0, 2, 0, 1, 0, 0, 1, 0);
    chk("tie2_B", last_win, 2);

    // A write then read back
    cyc(1, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("wr_we", 32'(obs_we), 1);
    cyc(1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("rd_valid", 32'(a_rvalid), 1);
    chk("rd_data", a_rdata, 32'hDEADBEEF);

    // continuous tie, no lock: strict alternation
    prev = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 32'(i), 0, 1, 0, 0, 32'(i + 8), 0);
      chk("alternate", last_win, (prev == 1) ? 2 : 1);
      prev = last_win;
    end

    // B locks every access while A waits: MaxLock grants to B, then A
    for (int i = 0; i < ML; i++) begin
      cyc(1, 1, 0, 0, 7, 0, 1, 1, 0, 32'(20 + i), 0);
      chk("lockB", last_win, 2);
    end
    cyc(1, 1, 0, 0, 7, 0, 1, 1, 0, 30, 0);
    chk("lock_end_A", last_win, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 30, 0);

    // A takes a lock then drops its request: B granted in that cycle
    cyc(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("lockA_gnt", last_win, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
    chk("release_B", last_win, 2);
    cyc(1, 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
    chk("idle_tie_A", last_win, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);

    // B write below ProtectBase and above it
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'h1234);
    chk("bw3_gnt", last_win, 2);
`ifdef ARB_B_WRITE_PROTECT_EN
    chk("bw3_we", 32'(obs_we), 0);
    chk("bw3_err", 32'(b_err), 1);
`else
    chk("bw3_we", 32'(obs_we), 1);
    chk("bw3_err", 32'(b_err), 0);
`endif
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
`ifdef ARB_B_WRITE_PROTECT_EN
    chk("bw3_rd", b_rdata, 0);
`else
    chk("bw3_rd", b_rdata, 32'h1234);
`endif
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 20, 32'h5678);
    chk("bw20_we", 32'(obs_we), 1);
    chk("bw20_err", 32'(b_err), 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 20, 0);
    chk("bw20_rd", b_rdata, 32'h5678);

    // reset while A owns a lock with a read in flight
    cyc(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 5, 0, 1, 0, 0, 6, 0);
    cyc(0, 1, 1, 0, 5, 0, 1, 0, 0, 6, 0);
    chk("midrst_rv", 32'(a_rvalid), 0);
    chk("midrst_rd", a_rdata, 0);
    cyc(1, 1, 0, 0, 5, 0, 1, 0, 0, 6, 0);
    chk("midrst_tie_A", last_win, 1);

    // randomized traffic; requests held until granted
    pa = 0; pb = 0;
    pla = 0; pwa = 0; paa = '0; pda = '0;
    plb = 0; pwb = 0; pab = '0; pdb = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; pla = 1'($urandom_range(0, 1)); pwa = 1'($urandom_range(0, 1));
        paa = 32'($urandom_range(0, 63)); pda = $urandom;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; plb = 1'($urandom_range(0, 1)); pwb = 1'($urandom_range(0, 1));
        pab = 32'($urandom_range(0, 63)); pdb = $urandom;
      end
      cyc(($urandom_range(0, 99) != 0), pa, pla, pwa, paa, pda, pb, plb, pwb, pab, pdb);
      if (last_win == 1) pa = 0;
      if (last_win == 2) pb = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
